// File: rtl/rgb_fade_sequencer.sv
// RGB LED colour-wheel sequencer: holds each colour, then PWM-crossfades to the next.
// Drives active-low LED pins from a registered copy of the per-channel on/off decision.
module rgb_fade_sequencer #(
   parameter int HOLD_CYCLES = 2000000,
   parameter int PWM_BITS    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_run,
   input  logic       i_step,
   output logic [2:0] o_color_idx,
   output logic       o_busy,
   output logic       RGB_R,
   output logic       RGB_G,
   output logic       RGB_B
);

   localparam int                  HW         = $clog2(HOLD_CYCLES);
   localparam logic [HW-1:0]       HOLD_LAST  = HW'(HOLD_CYCLES - 1);
   localparam logic [PWM_BITS-1:0] PWM_MAX    = '1;
   localparam logic [PWM_BITS:0]   DUTY_FULL  = {1'b1, {PWM_BITS{1'b0}}};

   typedef enum logic [1:0] {IDLE, HOLD, FADE} state_t;

   state_t              state_q, state_d;
   logic [2:0]          color_idx_q, color_idx_d;
   logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
   logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
   logic [PWM_BITS-1:0] level_q, level_d;
   logic [2:0]          pins_q, pins_d;
   logic [2:0]          cur_rgb, nxt_rgb, chan_on;

   // Colour bits are {R,G,B}, 1 = lit.
   function automatic logic [2:0] color_rgb(input logic [2:0] idx);
      case (idx)
         3'd0:    color_rgb = 3'b100;
         3'd1:    color_rgb = 3'b110;
         3'd2:    color_rgb = 3'b010;
         3'd3:    color_rgb = 3'b011;
         3'd4:    color_rgb = 3'b001;
         3'd5:    color_rgb = 3'b101;
         default: color_rgb = 3'b100;
      endcase
   endfunction

   function automatic logic [2:0] next_color(input logic [2:0] idx);
      next_color = (idx >= 3'd5) ? 3'd0 : idx + 3'd1;
   endfunction

   function automatic logic fade_on(input logic cur, input logic nxt,
                                    input logic [PWM_BITS-1:0] level,
                                    input logic [PWM_BITS-1:0] pwm);
      logic [PWM_BITS:0] duty;
      case ({cur, nxt})
         2'b11:   duty = DUTY_FULL;
         2'b01:   duty = {1'b0, level};
         2'b10:   duty = DUTY_FULL - {1'b0, level};
         default: duty = '0;
      endcase
      fade_on = ({1'b0, pwm} < duty);
   endfunction

   always_comb begin
      state_d     = state_q;
      color_idx_d = color_idx_q;
      hold_cnt_d  = hold_cnt_q;
      pwm_cnt_d   = pwm_cnt_q;
      level_d     = level_q;
      case (state_q)
         IDLE: begin
            if (i_run) begin
               state_d    = HOLD;
               hold_cnt_d = '0;
            end else if (i_step) begin
               color_idx_d = next_color(color_idx_q);
            end
         end
         HOLD: begin
            if (!i_run) begin
               state_d    = IDLE;
               hold_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d    = FADE;
               hold_cnt_d = '0;
               pwm_cnt_d  = '0;
               level_d    = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + HW'(1);
            end
         end
         FADE: begin
            pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
            if (pwm_cnt_q == PWM_MAX) begin
               if (level_q == PWM_MAX) begin
                  color_idx_d = next_color(color_idx_q);
                  level_d     = '0;
                  state_d     = i_run ? HOLD : IDLE;
               end else begin
                  level_d = level_q + PWM_BITS'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Channel decision is taken from the current registers and lands on the pins one clock later.
   always_comb begin
      cur_rgb = color_rgb(color_idx_q);
      nxt_rgb = color_rgb(next_color(color_idx_q));
      chan_on = cur_rgb;
      if (state_q == FADE) begin
         for (int i = 0; i < 3; i++) begin
            chan_on[i] = fade_on(cur_rgb[i], nxt_rgb[i], level_q, pwm_cnt_q);
         end
      end
      pins_d = ~chan_on;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         color_idx_q <= 3'd0;
         hold_cnt_q  <= '0;
         pwm_cnt_q   <= '0;
         level_q     <= '0;
         pins_q      <= 3'b011;
      end else begin
         state_q     <= state_d;
         color_idx_q <= color_idx_d;
         hold_cnt_q  <= hold_cnt_d;
         pwm_cnt_q   <= pwm_cnt_d;
         level_q     <= level_d;
         pins_q      <= pins_d;
      end
   end

   assign o_color_idx            = color_idx_q;
   assign o_busy                 = (state_q == FADE);
   assign {RGB_R, RGB_G, RGB_B}  = pins_q;

endmodule

// File: tb/tb_rgb_fade_sequencer.sv
// Directed self-checking bench for RgbFadeSequencer with HOLD_CYCLES=4, PWM_BITS=2.
// Pins are viewed as {R,G,B}, active low.
module tb_rgb_fade_sequencer;

   logic       clk;
   logic       rst;
   logic       iRun;
   logic       iStep;
   logic [2:0] colorIdx;
   logic       busy;
   logic       rgbR, rgbG, rgbB;
   logic [2:0] pins;

   int total = 0;
   int bad   = 0;

   rgb_fade_sequencer #(.HOLD_CYCLES(4), .PWM_BITS(2)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_run       (iRun),
      .i_step      (iStep),
      .o_color_idx (colorIdx),
      .o_busy      (busy),
      .RGB_R       (rgbR),
      .RGB_G       (rgbG),
      .RGB_B       (rgbB)
   );

   assign pins = {rgbR, rgbG, rgbB};

   // 100 MHz-style bench clock; only cycle counts matter here.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance n clocks and settle just past the rising edge before sampling.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Set the control inputs, then run for a number of clocks.
   task automatic applyStimulus(input logic rstV, input logic runV, input logic stepV, input int n);
      rst   = rstV;
      iRun  = runV;
      iStep = stepV;
      tick(n);
   endtask

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   initial begin
      rst = 1'b1; iRun = 1'b0; iStep = 1'b0;

      // Reset state and quiescence with no input.
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      checkOutput("rst_pins", 32'(pins), 32'h3);
      checkOutput("rst_idx", 32'(colorIdx), 32'h0);
      checkOutput("rst_busy", 32'(busy), 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 6);
      checkOutput("quiet_pins", 32'(pins), 32'h3);
      checkOutput("quiet_idx", 32'(colorIdx), 32'h0);
      checkOutput("quiet_busy", 32'(busy), 32'h0);

      // Run from reset release: 1 IDLE + 4 HOLD clocks before the fade starts.
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b1, 1'b0, 4);
      checkOutput("busy_pre", 32'(busy), 32'h0);
      tick(1);
      checkOutput("busy_rise", 32'(busy), 32'h1);
      // Red->yellow fade: G duty follows level, R solid on, B solid off.
      for (int k = 0; k < 16; k++) begin
         tick(1);
         checkOutput($sformatf("fade_g_%0d", k), 32'(rgbG), ((k % 4) < (k / 4)) ? 32'h0 : 32'h1);
         checkOutput($sformatf("fade_r_%0d", k), 32'(rgbR), 32'h0);
         checkOutput($sformatf("fade_b_%0d", k), 32'(rgbB), 32'h1);
         checkOutput($sformatf("fade_busy_%0d", k), 32'(busy), (k < 15) ? 32'h1 : 32'h0);
         checkOutput($sformatf("fade_idx_%0d", k), 32'(colorIdx), (k < 15) ? 32'h0 : 32'h1);
      end
      tick(1);
      checkOutput("yellow_pins", 32'(pins), 32'h1);

      // Full wheel: index advances every 20 clocks and wraps 5->0.
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      rst = 1'b0; iRun = 1'b1;
      for (int n = 1; n <= 121; n++) begin
         tick(1);
         checkOutput("idx_range", 32'(colorIdx > 3'd5), 32'h0);
         if ((n % 20) <= 1)
            checkOutput($sformatf("wheel_idx_%0d", n), 32'(colorIdx),
                        (n >= 21) ? 32'(((n - 1) / 20) % 6) : 32'h0);
      end

      // Single step in IDLE, step ignored in HOLD, run beats step.
      applyStimulus(1'b1, 1'b0, 1'b0, 2);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      checkOutput("step_idx", 32'(colorIdx), 32'h1);
      checkOutput("step_pins_lag", 32'(pins), 32'h3);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      checkOutput("step_pins", 32'(pins), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      checkOutput("hold_step_idx", 32'(colorIdx), 32'h1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1);
      applyStimulus(1'b0, 1'b1, 1'b1, 1);
      checkOutput("runstep_idx", 32'(colorIdx), 32'h1);
      applyStimulus(1'b0, 1'b1, 1'b0, 3);
      checkOutput("runstep_busy_pre", 32'(busy), 32'h0);
      tick(1);
      checkOutput("runstep_busy", 32'(busy), 32'h1);

      // Pause mid-fade: fade completes, then IDLE.
      applyStimulus(1'b0, 1'b1, 1'b0, 3);
      applyStimulus(1'b0, 1'b0, 1'b0, 12);
      checkOutput("pause_busy_end", 32'(busy), 32'h1);
      checkOutput("pause_idx_end", 32'(colorIdx), 32'h1);
      tick(1);
      checkOutput("pause_busy", 32'(busy), 32'h0);
      checkOutput("pause_idx", 32'(colorIdx), 32'h2);
      tick(25);
      checkOutput("pause_idle_busy", 32'(busy), 32'h0);
      checkOutput("pause_idle_idx", 32'(colorIdx), 32'h2);

      // Reset mid-fade.
      applyStimulus(1'b0, 1'b1, 1'b0, 8);
      checkOutput("midfade_busy", 32'(busy), 32'h1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1);
      checkOutput("midrst_idx", 32'(colorIdx), 32'h0);
      checkOutput("midrst_busy", 32'(busy), 32'h0);
      checkOutput("midrst_pins", 32'(pins), 32'h3);
      applyStimulus(1'b0, 1'b0, 1'b0, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
